// File: rtl/decode_unit.sv
// Decode stage for the rv32e core: combinational instruction decode feeding a
// two-entry skid buffer (main + skid register) so fetch_ready is registered.
// Optional feature macro: DECODE_RV32E_CHECK_EN -- when defined, a used
// rd/rs1/rs2 field naming x16..x31 marks the instruction illegal.

package decode_unit_pkg;

    typedef struct packed {
        logic [6:0]  opcode;
        logic [3:0]  destination;
        logic [3:0]  source_1;
        logic [3:0]  source_2;
        logic [2:0]  funct3;
        logic [6:0]  funct7;
        logic [31:0] immediate;
        logic [31:0] pc;
        logic        illegal;
    } decoded_t;

endpackage

module decode_unit
    import decode_unit_pkg::*;
(
    input  logic        clock,
    input  logic        reset,
    input  logic        fetch_valid,
    output logic        fetch_ready,
    input  logic [31:0] fetch_instruction,
    input  logic [31:0] fetch_pc,
    input  logic        flush,
    output logic        out_valid,
    input  logic        out_ready,
    output decoded_t    out_data
);

    localparam logic [6:0] OpLui    = 7'b0110111;
    localparam logic [6:0] OpAuipc  = 7'b0010111;
    localparam logic [6:0] OpJal    = 7'b1101111;
    localparam logic [6:0] OpJalr   = 7'b1100111;
    localparam logic [6:0] OpBranch = 7'b1100011;
    localparam logic [6:0] OpLoad   = 7'b0000011;
    localparam logic [6:0] OpStore  = 7'b0100011;
    localparam logic [6:0] OpOpImm  = 7'b0010011;
    localparam logic [6:0] OpOp     = 7'b0110011;
    localparam logic [6:0] OpMisc   = 7'b0001111;
    localparam logic [6:0] OpSystem = 7'b1110011;

    typedef enum logic [2:0] {FmtNone, FmtR, FmtI, FmtS, FmtB, FmtU, FmtJ} fmt_e;
    typedef enum logic [1:0] {StEmpty, StOne, StFull} state_e;

    logic [31:0] ins;
    fmt_e        fmt;
    logic        known;
    logic        use_rd;
    logic        use_rs1;
    logic        use_rs2;
    logic        reg_bad;
    decoded_t    dec;

    state_e      state_q, state_d;
    decoded_t    main_q, main_d;
    decoded_t    skid_q, skid_d;
    logic        fetch_ready_q, fetch_ready_d;
    logic        accept;
    logic        consume;

    assign ins = fetch_instruction;

    // Classify the opcode into an encoding format.
    always_comb begin
        fmt   = FmtNone;
        known = 1'b1;
        case (ins[6:0])
            OpLui, OpAuipc:                     fmt = FmtU;
            OpJal:                              fmt = FmtJ;
            OpJalr, OpLoad, OpOpImm, OpSystem:  fmt = FmtI;
            OpStore:                            fmt = FmtS;
            OpBranch:                           fmt = FmtB;
            OpOp:                               fmt = FmtR;
            OpMisc:                             fmt = FmtNone;
            default:                            known = 1'b0;
        endcase
    end

    // Immediate assembly and register-field usage per format.
    always_comb begin
        dec         = '0;
        use_rd      = 1'b0;
        use_rs1     = 1'b0;
        use_rs2     = 1'b0;
        case (fmt)
            FmtU: begin
                use_rd        = 1'b1;
                dec.immediate = {ins[31:12], 12'b0};
            end
            FmtJ: begin
                use_rd        = 1'b1;
                dec.immediate = {{12{ins[31]}}, ins[19:12], ins[20], ins[30:21], 1'b0};
            end
            FmtI: begin
                use_rd        = 1'b1;
                use_rs1       = 1'b1;
                dec.immediate = {{20{ins[31]}}, ins[31:20]};
            end
            FmtS: begin
                use_rs1       = 1'b1;
                use_rs2       = 1'b1;
                dec.immediate = {{20{ins[31]}}, ins[31:25], ins[11:7]};
            end
            FmtB: begin
                use_rs1       = 1'b1;
                use_rs2       = 1'b1;
                dec.immediate = {{20{ins[31]}}, ins[7], ins[30:25], ins[11:8], 1'b0};
            end
            FmtR: begin
                use_rd        = 1'b1;
                use_rs1       = 1'b1;
                use_rs2       = 1'b1;
            end
            default: ;
        endcase
        dec.opcode      = ins[6:0];
        dec.destination = use_rd  ? ins[10:7]  : 4'd0;
        dec.source_1    = use_rs1 ? ins[18:15] : 4'd0;
        dec.source_2    = use_rs2 ? ins[23:20] : 4'd0;
        dec.funct3      = ins[14:12];
        dec.funct7      = ins[31:25];
        dec.pc          = fetch_pc;
        dec.illegal     = (ins[1:0] != 2'b11) | ~known | reg_bad;
    end

`ifdef DECODE_RV32E_CHECK_EN
    assign reg_bad = (use_rd & ins[11]) | (use_rs1 & ins[19]) | (use_rs2 & ins[24]);
`else
    assign reg_bad = 1'b0;
`endif

    assign out_valid   = (state_q != StEmpty);
    assign fetch_ready = fetch_ready_q;
    assign out_data    = main_q;

    // Any word presented during a flush is dropped, not loaded.
    assign accept  = fetch_valid & fetch_ready_q & ~flush;
    assign consume = out_valid & out_ready;

    // Buffer next-state: main register feeds execute, skid catches overflow.
    always_comb begin
        state_d = state_q;
        main_d  = main_q;
        skid_d  = skid_q;
        unique case (state_q)
            StEmpty: begin
                if (accept) begin
                    main_d  = dec;
                    state_d = StOne;
                end
            end
            StOne: begin
                if (accept && !consume) begin
                    skid_d  = dec;
                    state_d = StFull;
                end else if (accept && consume) begin
                    main_d  = dec;
                end else if (consume) begin
                    state_d = StEmpty;
                end
            end
            StFull: begin
                if (consume) begin
                    main_d  = skid_q;
                    state_d = StOne;
                end
            end
            default: state_d = StEmpty;
        endcase
        if (flush) begin
            state_d = StEmpty;
        end
        fetch_ready_d = (state_d != StFull);
    end

    // State and data registers.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q       <= StEmpty;
            main_q        <= '0;
            skid_q        <= '0;
            fetch_ready_q <= 1'b1;
        end else begin
            state_q       <= state_d;
            main_q        <= main_d;
            skid_q        <= skid_d;
            fetch_ready_q <= fetch_ready_d;
        end
    end

endmodule

// File: tb/tb_decode_unit.sv
// Scoreboard bench for decode_unit: stimulus pushes expected records computed
// by a behavioural model; an independent monitor pops and compares on every
// output handshake.

module tb_decode_unit;
    import decode_unit_pkg::*;

`ifdef DECODE_RV32E_CHECK_EN
    localparam bit CheckEn = 1'b1;
`else
    localparam bit CheckEn = 1'b0;
`endif

    logic        clock;
    logic        reset;
    logic        fetch_valid;
    logic        fetch_ready;
    logic [31:0] fetch_instruction;
    logic [31:0] fetch_pc;
    logic        flush;
    logic        out_valid;
    logic        out_ready;
    decoded_t    out_data;

    int tests;
    int fails;
    decoded_t exp_q[$];

    decode_unit dut (
        .clock             (clock),
        .reset             (reset),
        .fetch_valid       (fetch_valid),
        .fetch_ready       (fetch_ready),
        .fetch_instruction (fetch_instruction),
        .fetch_pc          (fetch_pc),
        .flush             (flush),
        .out_valid         (out_valid),
        .out_ready         (out_ready),
        .out_data          (out_data)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    function automatic int bits(input logic [31:0] w, input int hi, input int lo);
        return int'((w >> lo) & ((32'd1 << (hi - lo + 1)) - 32'd1));
    endfunction

    // Reference decode from the ISA rules, using signed arithmetic on fields.
    function automatic decoded_t model(input logic [31:0] w, input logic [31:0] pc);
        decoded_t d;
        int  v;
        bit  rd, rs1, rs2, known, bad;
        d = '0;
        v = 0; rd = 0; rs1 = 0; rs2 = 0; known = 1;
        case (bits(w, 6, 0))
            'h37, 'h17: begin rd = 1; v = bits(w, 31, 12) << 12; end
            'h6F: begin
                rd = 1;
                v = (bits(w, 30, 21) << 1) + (bits(w, 20, 20) << 11)
                    + (bits(w, 19, 12) << 12) - (bits(w, 31, 31) << 20);
            end
            'h67, 'h03, 'h13, 'h73: begin
                rd = 1; rs1 = 1;
                v = bits(w, 30, 20) - bits(w, 31, 31) * 2048;
            end
            'h23: begin
                rs1 = 1; rs2 = 1;
                v = (bits(w, 30, 25) << 5) + bits(w, 11, 7) - bits(w, 31, 31) * 2048;
            end
            'h63: begin
                rs1 = 1; rs2 = 1;
                v = (bits(w, 11, 8) << 1) + (bits(w, 30, 25) << 5) + (bits(w, 7, 7) << 11)
                    - bits(w, 31, 31) * 4096;
            end
            'h33: begin rd = 1; rs1 = 1; rs2 = 1; end
            'h0F: ;
            default: known = 0;
        endcase
        bad = (rd && bits(w, 11, 11) == 1) || (rs1 && bits(w, 19, 19) == 1)
              || (rs2 && bits(w, 24, 24) == 1);
        d.opcode      = 7'(bits(w, 6, 0));
        d.destination = rd  ? 4'(bits(w, 10, 7))  : 4'd0;
        d.source_1    = rs1 ? 4'(bits(w, 18, 15)) : 4'd0;
        d.source_2    = rs2 ? 4'(bits(w, 23, 20)) : 4'd0;
        d.funct3      = 3'(bits(w, 14, 12));
        d.funct7      = 7'(bits(w, 31, 25));
        d.immediate   = v;
        d.pc          = pc;
        d.illegal     = (bits(w, 1, 0) != 3) || !known || (CheckEn && bad);
        return d;
    endfunction

    function automatic logic [31:0] rand_ins();
        logic [31:0] r;
        r = $urandom;
        case ($urandom_range(0, 12))
            0:  r[6:0] = 7'h37;
            1:  r[6:0] = 7'h17;
            2:  r[6:0] = 7'h6F;
            3:  r[6:0] = 7'h67;
            4:  r[6:0] = 7'h63;
            5:  r[6:0] = 7'h03;
            6:  r[6:0] = 7'h23;
            7:  r[6:0] = 7'h13;
            8:  r[6:0] = 7'h33;
            9:  r[6:0] = 7'h0F;
            10: r[6:0] = 7'h73;
            default: ;
        endcase
        return r;
    endfunction

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    // One cycle of stimulus; the scoreboard is updated after the monitor's sample.
    task automatic step(input logic fv, input logic [31:0] w, input logic [31:0] pc,
                        input logic ordy, input logic fl, output logic acc);
        @(negedge clock);
        fetch_valid       = fv;
        fetch_instruction = w;
        fetch_pc          = pc;
        out_ready         = ordy;
        flush             = fl;
        #2;
        acc = fv && fetch_ready && !fl;
        if (fl) exp_q.delete();
        else if (acc) exp_q.push_back(model(w, pc));
    endtask

    // Monitor: compare each consumed record and check stability under backpressure.
    initial begin
        decoded_t e;
        decoded_t held_data;
        logic     held;
        held = 1'b0;
        held_data = '0;
        forever begin
            @(negedge clock);
            #1;
            if (reset) begin
                held = 1'b0;
            end else begin
                if (held && out_valid) begin
                    tests++;
                    if (out_data !== held_data) begin
                        fails++;
                        $display("FAIL hold_stable: got %h expected %h", out_data, held_data);
                    end
                end
                if (out_valid && out_ready) begin
                    tests++;
                    if (exp_q.size() == 0) begin
                        fails++;
                        $display("FAIL unexpected_output: got pc %h expected no output",
                                 out_data.pc);
                    end else begin
                        e = exp_q.pop_front();
                        if (out_data !== e) begin
                            fails++;
                            $display("FAIL record pc=%h: got %h expected %h",
                                     e.pc, out_data, e);
                        end
                    end
                end
                held      = out_valid && !out_ready && !flush;
                held_data = out_data;
            end
        end
    end

    logic [31:0] d_ins [6] = '{32'h00500093, 32'h12345137, 32'h008000EF,
                               32'hFE208EE3, 32'h00100813, 32'h00000000};
    logic [6:0]  d_op  [6] = '{7'h13, 7'h37, 7'h6F, 7'h63, 7'h13, 7'h00};
    logic [3:0]  d_rd  [6] = '{4'd1, 4'd2, 4'd1, 4'd0, 4'd0, 4'd0};
    logic [3:0]  d_rs1 [6] = '{4'd0, 4'd0, 4'd0, 4'd1, 4'd0, 4'd0};
    logic [3:0]  d_rs2 [6] = '{4'd0, 4'd0, 4'd0, 4'd2, 4'd0, 4'd0};
    logic [31:0] d_imm [6] = '{32'd5, 32'h12345000, 32'd8, 32'hFFFFFFFC, 32'd1, 32'd0};
    logic        d_ill [6] = '{1'b0, 1'b0, 1'b0, 1'b0, CheckEn, 1'b1};

    initial begin
        logic        a;
        logic [31:0] pc;
        tests = 0;
        fails = 0;
        reset = 1'b1;
        fetch_valid = 1'b0;
        fetch_instruction = '0;
        fetch_pc = '0;
        flush = 1'b0;
        out_ready = 1'b0;
        repeat (2) @(negedge clock);
        #2;
        check("reset_fetch_ready", 32'(fetch_ready), 32'd1);
        check("reset_out_valid", 32'(out_valid), 32'd0);
        check("reset_out_data_hi", out_data[93:62], 32'd0);
        check("reset_out_data_lo", out_data[61:30], 32'd0);
        check("reset_out_data_rest", 32'(out_data[29:0]), 32'd0);
        reset = 1'b0;

        // Directed decodes, held under backpressure then consumed.
        for (int i = 0; i < 6; i++) begin
            step(1'b1, d_ins[i], 32'h100 + 32'(i * 4), 1'b0, 1'b0, a);
            check("dir_accept", 32'(a), 32'd1);
            step(1'b0, 32'd0, 32'd0, 1'b0, 1'b0, a);
            check("dir_valid", 32'(out_valid), 32'd1);
            check("dir_opcode", 32'(out_data.opcode), 32'(d_op[i]));
            check("dir_rd", 32'(out_data.destination), 32'(d_rd[i]));
            check("dir_rs1", 32'(out_data.source_1), 32'(d_rs1[i]));
            check("dir_rs2", 32'(out_data.source_2), 32'(d_rs2[i]));
            check("dir_imm", out_data.immediate, d_imm[i]);
            check("dir_pc", out_data.pc, 32'h100 + 32'(i * 4));
            check("dir_illegal", 32'(out_data.illegal), 32'(d_ill[i]));
            step(1'b0, 32'd0, 32'd0, 1'b1, 1'b0, a);
        end
        step(1'b0, 32'd0, 32'd0, 1'b0, 1'b0, a);
        check("dir_empty", 32'(out_valid), 32'd0);

        // Backpressure: two accepts fill the buffer, release drains in order.
        step(1'b1, 32'h00000013, 32'h0, 1'b0, 1'b0, a);
        check("bp_acc0", 32'(a), 32'd1);
        step(1'b1, 32'h00000013, 32'h4, 1'b0, 1'b0, a);
        check("bp_acc4", 32'(a), 32'd1);
        step(1'b1, 32'h00000013, 32'h8, 1'b0, 1'b0, a);
        check("bp_full_ready", 32'(fetch_ready), 32'd0);
        step(1'b1, 32'h00000013, 32'h8, 1'b1, 1'b0, a);
        check("bp_out0", out_data.pc, 32'h0);
        check("bp_noacc_full", 32'(a), 32'd0);
        step(1'b1, 32'h00000013, 32'h8, 1'b1, 1'b0, a);
        check("bp_out4", out_data.pc, 32'h4);
        check("bp_acc8", 32'(a), 32'd1);
        step(1'b0, 32'd0, 32'd0, 1'b1, 1'b0, a);
        check("bp_out8_valid", 32'(out_valid), 32'd1);
        check("bp_out8", out_data.pc, 32'h8);
        step(1'b0, 32'd0, 32'd0, 1'b1, 1'b0, a);
        check("bp_drained", 32'(out_valid), 32'd0);

        // Flush from FULL while fetch presents PC 0x20.
        step(1'b1, 32'h00000013, 32'h10, 1'b0, 1'b0, a);
        step(1'b1, 32'h00000013, 32'h14, 1'b0, 1'b0, a);
        step(1'b1, 32'h00000013, 32'h20, 1'b0, 1'b1, a);
        step(1'b0, 32'd0, 32'd0, 1'b1, 1'b0, a);
        check("flush_out_valid", 32'(out_valid), 32'd0);
        check("flush_fetch_ready", 32'(fetch_ready), 32'd1);
        repeat (3) step(1'b0, 32'd0, 32'd0, 1'b1, 1'b0, a);

        // Randomised traffic with occasional flushes.
        pc = 32'h1000;
        for (int n = 0; n < 3000; n++) begin
            step(($urandom % 4) != 0, rand_ins(), pc, ($urandom % 3) != 0,
                 ($urandom % 50) == 0, a);
            if (a) pc = pc + 32'd4;
        end

        // Drain with a bounded budget.
        for (int n = 0; n < 20 && exp_q.size() != 0; n++) begin
            step(1'b0, 32'd0, 32'd0, 1'b1, 1'b0, a);
        end
        check("drain_empty", 32'(exp_q.size()), 32'd0);

        // Asynchronous reset mid-stream.
        step(1'b1, 32'h00000013, 32'h200, 1'b0, 1'b0, a);
        step(1'b1, 32'h00000013, 32'h204, 1'b0, 1'b0, a);
        @(negedge clock);
        #3;
        reset = 1'b1;
        fetch_valid = 1'b0;
        #1;
        check("areset_out_valid", 32'(out_valid), 32'd0);
        check("areset_fetch_ready", 32'(fetch_ready), 32'd1);
        exp_q.delete();
        @(negedge clock);
        reset = 1'b0;
        step(1'b1, 32'h00000013, 32'h300, 1'b1, 1'b0, a);
        check("post_reset_accept", 32'(a), 32'd1);
        step(1'b0, 32'd0, 32'd0, 1'b1, 1'b0, a);
        check("post_reset_pc", out_data.pc, 32'h300);
        repeat (2) step(1'b0, 32'd0, 32'd0, 1'b1, 1'b0, a);
        check("final_empty", 32'(exp_q.size()), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
